// File: rtl/dr_pkg.sv
// Shared types and dual-rail helper functions for the wave sequencer slice.
// Vector helpers take a zero-padded DR_MAX_W vector plus the live width.
package dr_pkg;

  localparam int DR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE,
    FLUSH
  } dr_state_t;

  // Single-rail bit to dual-rail {t,f}; applied per bit, so any width works.
  function automatic logic [1:0] dr_encode(input logic d);
    return {d, ~d};
  endfunction

  function automatic logic dr_all_complete(input logic [DR_MAX_W-1:0] t,
                                           input logic [DR_MAX_W-1:0] f,
                                           input int w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < w) r = r & (t[i] ^ f[i]);
    end
    return r;
  endfunction

  function automatic logic dr_all_null(input logic [DR_MAX_W-1:0] t,
                                       input logic [DR_MAX_W-1:0] f,
                                       input int w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < w) r = r & ~t[i] & ~f[i];
    end
    return r;
  endfunction

  function automatic logic dr_any_illegal(input logic [DR_MAX_W-1:0] t,
                                          input logic [DR_MAX_W-1:0] f,
                                          input int w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < w) r = r | (t[i] & f[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/dr_wave_sequencer_if.sv
// Handshake and dual-rail bus bundle between the sequencer and its environment.
interface dr_wave_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [IN_W-1:0]  dr_t;
  logic [IN_W-1:0]  dr_f;
  logic [OUT_W-1:0] net_t;
  logic [OUT_W-1:0] net_f;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             err;

  modport slave (
    input  in_valid, in_data, net_t, net_f, out_ready,
    output in_ready, dr_t, dr_f, out_valid, out_data, err
  );

  modport master (
    output in_valid, in_data, net_t, net_f, out_ready,
    input  in_ready, dr_t, dr_f, out_valid, out_data, err
  );
endinterface

// File: rtl/dr_completion_detect.sv
// Combinational completion detector over a W-bit dual-rail vector.
module dr_completion_detect
  import dr_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] f,
  output logic         all_complete,
  output logic         all_null,
  output logic         any_illegal
);

  logic [DR_MAX_W-1:0] t_pad;
  logic [DR_MAX_W-1:0] f_pad;

  assign t_pad = DR_MAX_W'(t);
  assign f_pad = DR_MAX_W'(f);

  assign all_complete = dr_all_complete(t_pad, f_pad, W);
  assign all_null     = dr_all_null(t_pad, f_pad, W);
  assign any_illegal  = dr_any_illegal(t_pad, f_pad, W);

endmodule

// File: rtl/dr_wave_sequencer.sv
// Return-to-zero driver for a dual-rail network: encode, wait for completion,
// capture the result, then force a NULL spacer before the next word.
module dr_wave_sequencer
  import dr_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  dr_wave_sequencer_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dr_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [IN_W-1:0]  dr_t_reg;
  logic [IN_W-1:0]  dr_f_reg;
  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             err_reg;
  logic             taken_reg;

  logic [IN_W-1:0]  enc_t;
  logic [IN_W-1:0]  enc_f;
  logic             net_complete;
  logic             net_null;
  logic             net_illegal;
  logic             hs;

  for (genvar gi = 0; gi < IN_W; gi++) begin : g_enc
    assign {enc_t[gi], enc_f[gi]} = dr_encode(bus.in_data[gi]);
  end

  dr_completion_detect #(.W(OUT_W)) u_detect (
    .t            (bus.net_t),
    .f            (bus.net_f),
    .all_complete (net_complete),
    .all_null     (net_null),
    .any_illegal  (net_illegal)
  );

  assign hs = out_valid_reg & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dr_t_reg      <= '0;
      dr_f_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
      taken_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (bus.in_valid) begin
            dr_t_reg  <= enc_t;
            dr_f_reg  <= enc_f;
            state_reg <= EVAL;
          end
        end

        EVAL: begin
          if (net_illegal) begin
            err_reg   <= 1'b1;
            dr_t_reg  <= '0;
            dr_f_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= FLUSH;
          end else if (net_complete) begin
            out_data_reg  <= bus.net_t;
            out_valid_reg <= 1'b1;
            taken_reg     <= 1'b0;
            dr_t_reg      <= '0;
            dr_f_reg      <= '0;
            cnt_reg       <= '0;
            state_reg     <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            dr_t_reg  <= '0;
            dr_f_reg  <= '0;
            cnt_reg   <= '0;
            state_reg <= FLUSH;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          // The result is always delivered; a stuck spacer only raises err.
          if (hs) begin
            out_valid_reg <= 1'b0;
            taken_reg     <= 1'b1;
          end
          if (net_illegal) err_reg <= 1'b1;
          if ((taken_reg | hs) && net_null) begin
            taken_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        FLUSH: begin
          if (net_illegal) err_reg <= 1'b1;
          if (net_null) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.dr_t      = dr_t_reg;
  assign bus.dr_f      = dr_f_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.err       = err_reg;

endmodule
